// File: rtl/logic_or_window.sv
// Windowed sampler of the OR-gate stage output: sticky OR, ones count, rise count, first-one index.
// Latency: results and a one-cycle done pulse appear the cycle after the WINDOW-th accepted sample.
// Backpressure: none; in_valid=0 cycles are skipped, start is ignored while a window is in flight.
module logic_or_window #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             busy,
  output logic             done,
  output logic             any_one,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] first_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // All-ones doubles as the "no 1 seen" marker; WINDOW <= 2^CNT_W-1 keeps it distinct from any index.
  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0] idx_q, idx_d;
  logic             acc_or_q, acc_or_d;
  logic [CNT_W-1:0] acc_ones_q, acc_ones_d;
  logic [CNT_W-1:0] acc_rise_q, acc_rise_d;
  logic [CNT_W-1:0] acc_first_q, acc_first_d;
  logic             prev_q, prev_d;

  logic             res_or_q, res_or_d;
  logic [CNT_W-1:0] res_ones_q, res_ones_d;
  logic [CNT_W-1:0] res_rise_q, res_rise_d;
  logic [CNT_W-1:0] res_first_q, res_first_d;

  logic             accept;
  logic             last_sample;
  logic             launch;

  // Accumulator values including the current sample, used both for the
  // running update and for the result load on the final sample.
  logic             or_step;
  logic [CNT_W-1:0] ones_step;
  logic [CNT_W-1:0] rise_step;
  logic [CNT_W-1:0] first_step;

  assign accept      = (state_q == S_ACCUM) && in_valid;
  assign last_sample = accept && (idx_q == LAST_IDX);
  assign launch      = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

  assign or_step    = acc_or_q | in_bit;
  assign ones_step  = acc_ones_q + {{(CNT_W-1){1'b0}}, in_bit};
  assign rise_step  = acc_rise_q + {{(CNT_W-1){1'b0}}, (in_bit & ~prev_q)};
  assign first_step = (in_bit && (acc_first_q == ALL_ONES)) ? idx_q : acc_first_q;

  // State and datapath registers; reset discards any in-flight window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_or_q    <= 1'b0;
      acc_ones_q  <= '0;
      acc_rise_q  <= '0;
      acc_first_q <= ALL_ONES;
      prev_q      <= 1'b0;
      res_or_q    <= 1'b0;
      res_ones_q  <= '0;
      res_rise_q  <= '0;
      res_first_q <= ALL_ONES;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_or_q    <= acc_or_d;
      acc_ones_q  <= acc_ones_d;
      acc_rise_q  <= acc_rise_d;
      acc_first_q <= acc_first_d;
      prev_q      <= prev_d;
      res_or_q    <= res_or_d;
      res_ones_q  <= res_ones_d;
      res_rise_q  <= res_rise_d;
      res_first_q <= res_first_d;
    end
  end

  // Next-state logic: start only honoured outside ACCUM, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (last_sample) state_d = S_DONE;
      S_DONE:  state_d = start ? S_ACCUM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulators clear on window launch and step on each accepted sample.
  always_comb begin
    idx_d       = idx_q;
    acc_or_d    = acc_or_q;
    acc_ones_d  = acc_ones_q;
    acc_rise_d  = acc_rise_q;
    acc_first_d = acc_first_q;
    prev_d      = prev_q;
    if (launch) begin
      idx_d       = '0;
      acc_or_d    = 1'b0;
      acc_ones_d  = '0;
      acc_rise_d  = '0;
      acc_first_d = ALL_ONES;
      prev_d      = 1'b0;
    end else if (accept) begin
      idx_d       = idx_q + 1'b1;
      acc_or_d    = or_step;
      acc_ones_d  = ones_step;
      acc_rise_d  = rise_step;
      acc_first_d = first_step;
      prev_d      = in_bit;
    end
  end

  // Results load only on the final sample, so they hold across start and idle cycles.
  always_comb begin
    res_or_d    = res_or_q;
    res_ones_d  = res_ones_q;
    res_rise_d  = res_rise_q;
    res_first_d = res_first_q;
    if (last_sample) begin
      res_or_d    = or_step;
      res_ones_d  = ones_step;
      res_rise_d  = rise_step;
      res_first_d = first_step;
    end
  end

  // Output decode: status flags straight from the state register.
  always_comb begin
    busy      = (state_q == S_ACCUM);
    done      = (state_q == S_DONE);
    any_one   = res_or_q;
    ones_cnt  = res_ones_q;
    rise_cnt  = res_rise_q;
    first_idx = res_first_q;
  end

endmodule

// File: tb/tb_logic_or_window.sv
// Directed bench for logic_or_window (WINDOW=8, CNT_W=4).
// Inputs driven 1 time unit after each rising edge; outputs checked in the same slot.
// Table of windows plus hand sequences for reset, mid-window start and back-to-back.
module tb_logic_or_window;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_bit;
  logic       busy;
  logic       done;
  logic       any_one;
  logic [3:0] ones_cnt;
  logic [3:0] rise_cnt;
  logic [3:0] first_idx;

  int checks = 0;
  int errors = 0;

  logic_or_window #(.WINDOW(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .busy      (busy),
    .done      (done),
    .any_one   (any_one),
    .ones_cnt  (ones_cnt),
    .rise_cnt  (rise_cnt),
    .first_idx (first_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] pat;     // bit i = sample i
    bit         gaps;    // 3 invalid cycles (in_bit=1) after samples 2 and 5
    logic       exp_any;
    int         exp_ones;
    int         exp_rise;
    int         exp_first;
    int         exp_lat; // start edge to done, in cycles
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_results(input string tag, input logic e_any, input int e_ones,
                             input int e_rise, input int e_first);
    chk({tag, ".any_one"}, int'(any_one), int'(e_any));
    chk({tag, ".ones_cnt"}, int'(ones_cnt), e_ones);
    chk({tag, ".rise_cnt"}, int'(rise_cnt), e_rise);
    chk({tag, ".first_idx"}, int'(first_idx), e_first);
  endtask

  // Feed 8 samples (window already started, lat0 cycles counted) and wait for done.
  task automatic feed(input logic [7:0] pat, input bit gaps, input bit mid_start,
                      input int lat0, output int lat, output bit early_done);
    lat = lat0;
    early_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gaps && (i == 3 || i == 6)) begin
        for (int g = 0; g < 3; g++) begin
          in_valid = 1'b0; in_bit = 1'b1; start = 1'b0;
          step(); lat++;
          if (done) early_done = 1'b1;
        end
      end
      in_valid = 1'b1;
      in_bit   = pat[i];
      start    = mid_start && (i == 3);
      step(); lat++;
      if (done && i != 7) early_done = 1'b1;
    end
    in_valid = 1'b0; in_bit = 1'b0; start = 1'b0;
    while (!done && lat < 60) begin
      step(); lat++;
    end
  endtask

  task automatic begin_window();
    start = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
    step();
    start = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  lat;
    bit  early;
    int  done_seen;

    vecs[0] = '{"all_zero",   8'h00, 1'b0, 1'b0, 0, 0, 15, 9};
    vecs[1] = '{"pattern",    8'h96, 1'b0, 1'b1, 4, 3, 1,  9};
    vecs[2] = '{"pat_gaps",   8'h96, 1'b1, 1'b1, 4, 3, 1,  15};
    vecs[3] = '{"last_only",  8'h80, 1'b0, 1'b1, 1, 1, 7,  9};
    vecs[4] = '{"first_only", 8'h01, 1'b0, 1'b1, 1, 1, 0,  9};
    vecs[5] = '{"alt_gaps",   8'hAA, 1'b1, 1'b1, 4, 4, 1,  15};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    step(); step();
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk_results("rst", 1'b0, 0, 0, 15);
    rst = 1'b0;
    // Idle with toggling samples but no start: nothing may change.
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_bit = i[0];
      step();
      if (busy || done) done_seen++;
    end
    in_valid = 1'b0;
    chk("idle.no_activity", done_seen, 0);
    chk_results("idle", 1'b0, 0, 0, 15);

    // Table-driven windows.
    for (int v = 0; v < 6; v++) begin
      begin_window();
      chk({vecs[v].name, ".busy_after_start"}, int'(busy), 1);
      feed(vecs[v].pat, vecs[v].gaps, 1'b0, 1, lat, early);
      chk({vecs[v].name, ".early_done"}, int'(early), 0);
      chk({vecs[v].name, ".latency"}, lat, vecs[v].exp_lat);
      chk({vecs[v].name, ".done"}, int'(done), 1);
      chk({vecs[v].name, ".busy_at_done"}, int'(busy), 0);
      chk_results(vecs[v].name, vecs[v].exp_any, vecs[v].exp_ones,
                  vecs[v].exp_rise, vecs[v].exp_first);
      step(); step();
      chk({vecs[v].name, ".done_pulse"}, int'(done), 0);
      chk_results({vecs[v].name, ".hold"}, vecs[v].exp_any, vecs[v].exp_ones,
                  vecs[v].exp_rise, vecs[v].exp_first);
    end

    // Start with results present: they must survive the new start.
    begin_window();
    chk_results("start_keeps", 1'b1, 4, 4, 1);

    // Reset after 4 accepted samples, with start and in_valid also high.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      step();
    end
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    chk_results("midrst", 1'b0, 0, 0, 15);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      step();
      if (done || busy) done_seen++;
    end
    in_valid = 1'b0;
    chk("midrst.no_done", done_seen, 0);
    begin_window();
    feed(8'hFF, 1'b0, 1'b0, 1, lat, early);
    chk("ones.latency", lat, 9);
    chk("ones.done", int'(done), 1);
    chk_results("ones", 1'b1, 8, 1, 0);
    step();

    // Start pulsed mid-window is ignored; start held in DONE chains the next window.
    begin_window();
    feed(8'h96, 1'b0, 1'b1, 1, lat, early);
    chk("midstart.early_done", int'(early), 0);
    chk("midstart.latency", lat, 9);
    chk("midstart.done", int'(done), 1);
    chk_results("midstart", 1'b1, 4, 3, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b.busy", int'(busy), 1);
    chk("b2b.done_low", int'(done), 0);
    feed(8'h55, 1'b0, 1'b0, 1, lat, early);
    chk("b2b.latency", lat, 9);
    chk("b2b.done", int'(done), 1);
    chk_results("b2b", 1'b1, 4, 4, 0);
    step();
    chk("b2b.idle_busy", int'(busy), 0);
    chk("b2b.idle_done", int'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
